stdp_weight_update: RTL and testbench

- Trace-based STDP learning stage downstream of the coupled Izhikevich neuron pair.
- Consumes per-step presynaptic/postsynaptic spike flags plus the neuron array's apply strobe.
- Maintains decaying pre/post eligibility traces and a synaptic weight, all signed fixed point.
- Produces the updated weight that drives the synaptic current back into the postsynaptic neuron.

---
 rtl/stdp_pkg.sv | 27 ++
 rtl/stdp_weight_update_fixed_mul.sv | 29 ++
 rtl/stdp_weight_update.sv | 97 +++++++++
 tb/tb_stdp_weight_update.sv | 214 +++++++++++++++++++++
 4 files changed

// File: rtl/stdp_pkg.sv
// Shared definitions for the STDP weight-update stage.
//   N_DEF / Q_DEF : default total width and fractional bits of the signed fixed-point format
//   fixed_t       : signed fixed-point word at the default width
//   FX_ONE        : 1.0 in the default format
//   FX_MAX/FX_MIN : saturation limits of the default format
//   clamp()       : signed clamp on a 64-bit carrier; callers sign-extend in and truncate out,
//                   so it serves any N up to 62
package stdp_pkg;

  localparam int unsigned N_DEF = 32;
  localparam int unsigned Q_DEF = 16;

  typedef logic signed [N_DEF-1:0] fixed_t;

  localparam fixed_t FX_ONE = fixed_t'(1 << Q_DEF);
  localparam fixed_t FX_MAX = {1'b0, {(N_DEF-1){1'b1}}};
  localparam fixed_t FX_MIN = {1'b1, {(N_DEF-1){1'b0}}};

  function automatic logic signed [63:0] clamp(input logic signed [63:0] x,
                                                input logic signed [63:0] lo,
                                                input logic signed [63:0] hi);
    if (x < lo)      return lo;
    else if (x > hi) return hi;
    else             return x;
  endfunction

endpackage

// File: rtl/stdp_weight_update_fixed_mul.sv
// Signed Q-format multiply with saturation.
//   a, b : signed N-bit operands with Q fractional bits
//   p    : (a*b) >>> Q, saturated to the signed N-bit range
module fixed_mul
  import stdp_pkg::*;
#(
  parameter int unsigned N = N_DEF,
  parameter int unsigned Q = Q_DEF
) (
  input  logic signed [N-1:0] a,
  input  logic signed [N-1:0] b,
  output logic signed [N-1:0] p
);

  localparam logic signed [2*N-1:0] HI = {{(N+1){1'b0}}, {(N-1){1'b1}}};
  localparam logic signed [2*N-1:0] LO = {{(N+1){1'b1}}, {(N-1){1'b0}}};

  logic signed [2*N-1:0] prod;
  logic signed [2*N-1:0] shifted;

  always_comb begin
    prod    = (2*N)'(a) * (2*N)'(b);
    shifted = prod >>> Q;
    if (shifted > HI)      p = HI[N-1:0];
    else if (shifted < LO) p = LO[N-1:0];
    else                   p = shifted[N-1:0];
  end

endmodule

// File: rtl/stdp_weight_update.sv
// Trace-based STDP learning stage.
//   clk, rst_n        : clock, asynchronous active-low reset
//   apply             : simulation-step strobe, samples pre_spike / post_spike
//   pre_spike/post_spike : spike flags for this step
//   load, weight_init : load weight (unclamped), clear traces, flush pipeline
//   a_plus, a_minus   : LTP / LTD amplitudes
//   decay_pre/post    : per-step trace multipliers
//   w_min, w_max      : weight clamp bounds
//   weight, weight_valid : current weight and one-cycle update pulse
//   pre_trace, post_trace : eligibility traces
// Stage 1 (apply edge) forms ltp/ltd from the traces held before the edge and decays the
// traces; stage 2 (next edge) accumulates the delta into the clamped weight.
module stdp_weight_update
  import stdp_pkg::*;
#(
  parameter int unsigned N = N_DEF,
  parameter int unsigned Q = Q_DEF
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                apply,
  input  logic                pre_spike,
  input  logic                post_spike,
  input  logic                load,
  input  logic signed [N-1:0] weight_init,
  input  logic signed [N-1:0] a_plus,
  input  logic signed [N-1:0] a_minus,
  input  logic signed [N-1:0] decay_pre,
  input  logic signed [N-1:0] decay_post,
  input  logic signed [N-1:0] w_min,
  input  logic signed [N-1:0] w_max,
  output logic signed [N-1:0] weight,
  output logic                weight_valid,
  output logic signed [N-1:0] pre_trace,
  output logic signed [N-1:0] post_trace
);

  localparam logic signed [N:0] ONE_W = (N+1)'(1) << Q;

  logic signed [N-1:0] ltp_p, ltd_p, pre_dec, post_dec;
  logic signed [N-1:0] ltp_r, ltd_r;
  logic                s1_valid;
  logic signed [N:0]   pre_sum, post_sum;
  logic signed [N-1:0] pre_next, post_next;
  logic signed [N+1:0] w_next;
  logic signed [N-1:0] w_clamped;

  fixed_mul #(.N(N), .Q(Q)) u_ltp       (.a(a_plus),     .b(pre_trace),  .p(ltp_p));
  fixed_mul #(.N(N), .Q(Q)) u_ltd       (.a(a_minus),    .b(post_trace), .p(ltd_p));
  fixed_mul #(.N(N), .Q(Q)) u_pre_decay (.a(pre_trace),  .b(decay_pre),  .p(pre_dec));
  fixed_mul #(.N(N), .Q(Q)) u_post_decay(.a(post_trace), .b(decay_post), .p(post_dec));

  // One extra bit holds the spike increment; overflow shows as a disagreement of the top two bits.
  always_comb begin
    pre_sum  = (N+1)'(pre_dec)  + (pre_spike  ? ONE_W : '0);
    post_sum = (N+1)'(post_dec) + (post_spike ? ONE_W : '0);
    if (pre_sum[N] != pre_sum[N-1])
      pre_next = pre_sum[N] ? {1'b1, {(N-1){1'b0}}} : {1'b0, {(N-1){1'b1}}};
    else
      pre_next = pre_sum[N-1:0];
    if (post_sum[N] != post_sum[N-1])
      post_next = post_sum[N] ? {1'b1, {(N-1){1'b0}}} : {1'b0, {(N-1){1'b1}}};
    else
      post_next = post_sum[N-1:0];
    w_next    = (N+2)'(weight) + (N+2)'(ltp_r) - (N+2)'(ltd_r);
    w_clamped = N'(clamp(64'(w_next), 64'(w_min), 64'(w_max)));
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      weight       <= '0;
      weight_valid <= 1'b0;
      pre_trace    <= '0;
      post_trace   <= '0;
      ltp_r        <= '0;
      ltd_r        <= '0;
      s1_valid     <= 1'b0;
    end else if (load) begin
      weight       <= weight_init;
      weight_valid <= 1'b0;
      pre_trace    <= '0;
      post_trace   <= '0;
      s1_valid     <= 1'b0;
    end else begin
      if (apply) begin
        ltp_r      <= post_spike ? ltp_p : '0;
        ltd_r      <= pre_spike  ? ltd_p : '0;
        pre_trace  <= pre_next;
        post_trace <= post_next;
      end
      s1_valid     <= apply;
      if (s1_valid) weight <= w_clamped;
      weight_valid <= s1_valid;
    end
  end

endmodule

// File: tb/tb_stdp_weight_update.sv
module tb_stdp_weight_update;

  logic               clk = 1'b0;
  logic               rst_n = 1'b0;
  logic               apply = 1'b0, pre_spike = 1'b0, post_spike = 1'b0, load = 1'b0;
  logic signed [31:0] weight_init = '0, a_plus = '0, a_minus = '0;
  logic signed [31:0] decay_pre = '0, decay_post = '0, w_min = '0, w_max = '0;
  logic signed [31:0] weight, pre_trace, post_trace;
  logic               weight_valid;

  int n_checks = 0;
  int n_fail   = 0;

  localparam longint ONE  = 64'sd65536;
  localparam longint SMAX = 64'sd2147483647;
  localparam longint SMIN = -64'sd2147483648;

  stdp_weight_update dut (
    .clk(clk), .rst_n(rst_n), .apply(apply), .pre_spike(pre_spike), .post_spike(post_spike),
    .load(load), .weight_init(weight_init), .a_plus(a_plus), .a_minus(a_minus),
    .decay_pre(decay_pre), .decay_post(decay_post), .w_min(w_min), .w_max(w_max),
    .weight(weight), .weight_valid(weight_valid), .pre_trace(pre_trace), .post_trace(post_trace)
  );

  always #5 clk = ~clk;

  // ---------------- behavioural reference ----------------
  function automatic longint sat32(input longint x);
    if (x > SMAX) return SMAX;
    if (x < SMIN) return SMIN;
    return x;
  endfunction

  function automatic longint fxmul(input longint x, input longint y);
    return sat32((x * y) >>> 16);
  endfunction

  longint m_w = 0, m_pre = 0, m_post = 0, m_delta = 0;
  bit     m_pending = 0, m_valid = 0;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_w = 0; m_pre = 0; m_post = 0; m_delta = 0; m_pending = 0; m_valid = 0;
    end else if (load) begin
      m_w = longint'(weight_init); m_pre = 0; m_post = 0; m_pending = 0; m_valid = 0;
    end else begin
      if (m_pending) begin
        m_w = m_w + m_delta;
        if (m_w < longint'(w_min)) m_w = longint'(w_min);
        if (m_w > longint'(w_max)) m_w = longint'(w_max);
      end
      m_valid = m_pending;
      if (apply) begin
        m_delta = (post_spike ? fxmul(longint'(a_plus), m_pre) : 0)
                - (pre_spike  ? fxmul(longint'(a_minus), m_post) : 0);
        m_pre  = sat32(fxmul(m_pre,  longint'(decay_pre))  + (pre_spike  ? ONE : 0));
        m_post = sat32(fxmul(m_post, longint'(decay_post)) + (post_spike ? ONE : 0));
      end
      m_pending = apply;
    end
  end

  task automatic chk(input string nm, input longint act, input longint exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", nm, act, exp, $time);
    end
  endtask

  // Every-cycle comparison against the model.
  always @(negedge clk) begin
    chk("model_weight",       longint'(weight),       m_w);
    chk("model_weight_valid", longint'(weight_valid), longint'(m_valid));
    chk("model_pre_trace",    longint'(pre_trace),    m_pre);
    chk("model_post_trace",   longint'(post_trace),   m_post);
  end

  // ---------------- stimulus helpers ----------------
  task automatic do_load(input logic signed [31:0] w);
    @(negedge clk); load = 1'b1; weight_init = w; apply = 1'b0;
    @(negedge clk); load = 1'b0;
  endtask

  // Returns on the negedge after the stage-2 edge of this apply.
  task automatic do_apply(input logic pr, input logic po);
    @(negedge clk); apply = 1'b1; pre_spike = pr; post_spike = po;
    @(negedge clk); apply = 1'b0; pre_spike = 1'b0; post_spike = 1'b0;
    @(negedge clk);
  endtask

  initial begin
    w_min = 32'sh8000_0000; w_max = 32'sh7FFF_FFFF;
    decay_pre = 32'sh0000_8000; decay_post = 32'sh0000_8000;

    // Reset held while inputs toggle
    repeat (4) begin
      @(negedge clk); apply = ~apply; pre_spike = ~pre_spike; post_spike = 1'b1;
    end
    @(negedge clk);
    chk("rst_weight", longint'(weight), 0);
    chk("rst_valid",  longint'(weight_valid), 0);
    chk("rst_pre",    longint'(pre_trace), 0);
    chk("rst_post",   longint'(post_trace), 0);
    apply = 1'b0; pre_spike = 1'b0; post_spike = 1'b0;
    #1 rst_n = 1'b1;

    // Load + pre spike
    do_load(32'sh0000_8000);
    do_apply(1'b1, 1'b0);
    chk("pre_valid",  longint'(weight_valid), 1);
    chk("pre_weight", longint'(weight), 64'h8000);
    chk("pre_trace1", longint'(pre_trace), 64'h10000);

    // LTP
    a_plus = 32'sh0000_4000;
    do_apply(1'b0, 1'b1);
    chk("ltp_weight", longint'(weight), 64'hC000);
    chk("ltp_pre",    longint'(pre_trace), 64'h8000);
    chk("ltp_post",   longint'(post_trace), 64'h10000);

    // LTD
    a_minus = 32'sh0000_2000;
    do_apply(1'b1, 1'b0);
    chk("ltd_weight", longint'(weight), 64'hA000);
    chk("ltd_pre",    longint'(pre_trace), 64'h14000);

    // Clamp at w_max
    w_max = 32'sh0001_0000;
    do_load(32'sh0000_F000);
    do_apply(1'b1, 1'b0);
    chk("clamp_pre", longint'(pre_trace), 64'h10000);
    do_apply(1'b0, 1'b1);
    chk("clamp_weight", longint'(weight), 64'h10000);
    w_max = 32'sh7FFF_FFFF;

    // Simultaneous spikes
    do_load(32'sh0000_0000);
    do_apply(1'b1, 1'b1);
    chk("sim1_weight", longint'(weight), 0);
    chk("sim1_post",   longint'(post_trace), 64'h10000);
    do_apply(1'b1, 1'b1);
    chk("sim2_weight", longint'(weight), 64'h2000);
    chk("sim2_pre",    longint'(pre_trace), 64'h18000);

    // No apply: hold
    repeat (3) @(negedge clk);
    chk("idle_valid",  longint'(weight_valid), 0);
    chk("idle_pre",    longint'(pre_trace), 64'h18000);
    chk("idle_weight", longint'(weight), 64'h2000);

    // Load discards an in-flight update
    @(negedge clk); apply = 1'b1; post_spike = 1'b1;
    @(negedge clk); apply = 1'b0; post_spike = 1'b0; load = 1'b1; weight_init = 32'sh0000_1234;
    @(negedge clk); load = 1'b0;
    chk("flush_weight", longint'(weight), 64'h1234);
    chk("flush_valid",  longint'(weight_valid), 0);
    chk("flush_post",   longint'(post_trace), 0);
    @(negedge clk);
    chk("flush_valid2", longint'(weight_valid), 0);

    // Reset mid-pipeline
    do_apply(1'b1, 1'b0);
    @(negedge clk); apply = 1'b1; post_spike = 1'b1;
    @(negedge clk); apply = 1'b0; post_spike = 1'b0;
    #1 rst_n = 1'b0;
    repeat (3) begin
      @(negedge clk);
      chk("midrst_valid", longint'(weight_valid), 0);
    end
    #1 rst_n = 1'b1;
    repeat (3) begin
      @(negedge clk);
      chk("post_rst_valid",  longint'(weight_valid), 0);
      chk("post_rst_weight", longint'(weight), 0);
    end

    // Randomised operation, checked every cycle by the compare process
    for (int i = 0; i < 3000; i++) begin
      @(negedge clk);
      if (i % 50 == 0) begin
        if ($urandom_range(0, 3) == 0) begin
          a_plus  = $urandom;
          a_minus = $urandom;
          decay_pre  = $urandom;
          decay_post = $urandom_range(0, 32'h0002_0000);
        end else begin
          a_plus  = $urandom_range(0, 32'h0003_0000);
          a_minus = $urandom_range(0, 32'h0003_0000);
          decay_pre  = $urandom_range(0, 32'h0001_0000);
          decay_post = $urandom_range(0, 32'h0001_0000);
        end
        w_min = -$signed($urandom_range(0, 32'h0004_0000));
        w_max =  $signed($urandom_range(0, 32'h0004_0000));
      end
      apply      = ($urandom_range(0, 3) != 0);
      pre_spike  = ($urandom_range(0, 2) == 0);
      post_spike = ($urandom_range(0, 2) == 0);
      load       = ($urandom_range(0, 63) == 0);
      weight_init = $signed($urandom_range(0, 32'h0008_0000)) - 32'sh0004_0000;
      if ($urandom_range(0, 499) == 0) begin
        #1 rst_n = 1'b0;
        @(negedge clk);
        #1 rst_n = 1'b1;
      end
    end
    @(negedge clk); apply = 1'b0; load = 1'b0;
    repeat (3) @(negedge clk);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
